// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared 640x480 @ 60 Hz raster constants and the pixel-coordinate type used
//   by the timing generator and every mapper that consumes DrawX/DrawY.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;  // 800
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;  // 525

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis: a wrapping counter plus its active-low sync and visible
//   flags. The flags are registered from the next count, so they change on the
//   same edge as the count they describe.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en         advance the counter on this edge
//   count      current position, 0..TOTAL-1
//   wrap       combinational: this enabled edge takes count from TOTAL-1 to 0
//   sync_n     low while SYNC_START <= count < SYNC_END
//   visible    high while count < VISIBLE
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int VISIBLE    = H_VISIBLE,
    parameter int SYNC_START = H_VISIBLE + H_FP,
    parameter int SYNC_END   = H_VISIBLE + H_FP + H_SYNC
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output logic   wrap,
    output logic   sync_n,
    output logic   visible
);

    localparam coord_t LAST   = coord_t'(TOTAL - 1);
    localparam coord_t VIS    = coord_t'(VISIBLE);
    localparam coord_t SYNC_S = coord_t'(SYNC_START);
    localparam coord_t SYNC_E = coord_t'(SYNC_END);

    coord_t count_nxt;

    always_comb begin
        wrap      = en && (count == LAST);
        count_nxt = count;
        if (en)
            count_nxt = wrap ? '0 : count + coord_t'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            sync_n  <= 1'b1;
            visible <= 1'b1;        // position 0 is inside the visible area
        end else begin
            count   <= count_nxt;
            sync_n  <= !((count_nxt >= SYNC_S) && (count_nxt < SYNC_E));
            visible <= (count_nxt < VIS);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing from the system clock. A toggling pixel enable halves
//   the clock; the horizontal axis advances on enabled edges and the vertical
//   axis on horizontal wraps.
// Ports:
//   Clk          system clock (2 Clk per pixel)
//   Reset        asynchronous active-high reset
//   pixel_clk    Clk/2, straight from the pixel-enable register
//   hs, vs       active-low syncs, aligned with DrawX/DrawY
//   blank        1 = active video
//   sync         composite sync, always 0
//   DrawX/DrawY  raw raster counters (not clamped; gate on blank)
//   frame_start  one-Clk pulse on the first (0,0) cycle after a frame wrap
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic   Clk,
    input  logic   Reset,
    output logic   pixel_clk,
    output logic   hs,
    output logic   vs,
    output logic   blank,
    output logic   sync,
    output coord_t DrawX,
    output coord_t DrawY,
    output logic   frame_start
);

    logic pix_en;
    logic h_wrap, v_wrap;
    logic h_vis, v_vis;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pix_en      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= ~pix_en;
            // v_wrap fires on the edge that loads (0,0), so this register
            // rises exactly when the counters first show the new frame.
            frame_start <= v_wrap;
        end
    end

    vga_axis_counter #(
        .TOTAL      (H_VISIBLE + H_FP + H_SYNC + H_BP),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FP),
        .SYNC_END   (H_VISIBLE + H_FP + H_SYNC)
    ) u_h (
        .clk     (Clk),
        .rst     (Reset),
        .en      (pix_en),
        .count   (DrawX),
        .wrap    (h_wrap),
        .sync_n  (hs),
        .visible (h_vis)
    );

    vga_axis_counter #(
        .TOTAL      (V_VISIBLE + V_FP + V_SYNC + V_BP),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FP),
        .SYNC_END   (V_VISIBLE + V_FP + V_SYNC)
    ) u_v (
        .clk     (Clk),
        .rst     (Reset),
        .en      (h_wrap),
        .count   (DrawY),
        .wrap    (v_wrap),
        .sync_n  (vs),
        .visible (v_vis)
    );

    // Both visible flags are registers updated on the same edge as the
    // counters, so their AND adds no skew relative to DrawX/DrawY.
    assign blank     = h_vis & v_vis;
    assign pixel_clk = pix_en;
    assign sync      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: one instance at the standard 640x480 timing (covers the
// first lines) and one with a shrunken raster so several whole frames,
// vertical sync and frame_start fit in a short run.
module tb_vga_timing_gen;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic       d_pclk, d_hs, d_vs, d_blank, d_sync, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_pclk, s_hs, s_vs, s_blank, s_sync, s_fs;
    logic [9:0] s_x, s_y;

    vga_timing_gen dut (
        .Clk(Clk), .Reset(Reset), .pixel_clk(d_pclk), .hs(d_hs), .vs(d_vs),
        .blank(d_blank), .sync(d_sync), .DrawX(d_x), .DrawY(d_y),
        .frame_start(d_fs)
    );

    // Small raster: 25 pixels x 19 lines, hsync 18..21, vsync 14..15.
    localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3;
    localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) dut_s (
        .Clk(Clk), .Reset(Reset), .pixel_clk(s_pclk), .hs(s_hs), .vs(s_vs),
        .blank(s_blank), .sync(s_sync), .DrawX(s_x), .DrawY(s_y),
        .frame_start(s_fs)
    );

    typedef struct {
        int pclk, hs, vs, blank, sync, x, y, fs;
    } obs_t;

    typedef struct {
        obs_t d;
        obs_t s;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   k = 0;    // Clk edges seen since reset was released

    // Reference: after k edges out of reset, k/2 pixels have elapsed.
    function automatic obs_t model(int kk, bit rst, int hv, int hf, int hsy,
                                   int hb, int vv, int vf, int vsy, int vb);
        obs_t o;
        int ht, vt, p;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vb;
        p  = kk / 2;
        if (rst) begin
            o = '{pclk:0, hs:1, vs:1, blank:1, sync:0, x:0, y:0, fs:0};
        end else begin
            o.pclk  = kk % 2;
            o.x     = p % ht;
            o.y     = (p / ht) % vt;
            o.hs    = (o.x >= hv + hf && o.x < hv + hf + hsy) ? 0 : 1;
            o.vs    = (o.y >= vv + vf && o.y < vv + vf + vsy) ? 0 : 1;
            o.blank = (o.x < hv && o.y < vv) ? 1 : 0;
            o.sync  = 0;
            o.fs    = (kk > 0 && kk % 2 == 0 && p % (ht * vt) == 0) ? 1 : 0;
        end
        return o;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp(string tag, obs_t a, obs_t e);
        chk({tag, ".pixel_clk"},   a.pclk,  e.pclk);
        chk({tag, ".hs"},          a.hs,    e.hs);
        chk({tag, ".vs"},          a.vs,    e.vs);
        chk({tag, ".blank"},       a.blank, e.blank);
        chk({tag, ".sync"},        a.sync,  e.sync);
        chk({tag, ".DrawX"},       a.x,     e.x);
        chk({tag, ".DrawY"},       a.y,     e.y);
        chk({tag, ".frame_start"}, a.fs,    e.fs);
    endtask

    // Reset only ever changes away from rising edges, so sampling it here is
    // unambiguous.
    always @(posedge Clk) begin
        if (Reset) k = 0;
        else       k = k + 1;
    end

    // Producer: expected outputs for this cycle.
    always @(negedge Clk) begin
        exp_t e;
        e.d = model(k, Reset, 640, 16, 96, 48, 480, 10, 2, 33);
        e.s = model(k, Reset, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
        sb.push_back(e);
    end

    // Monitor: sample the DUTs mid-cycle and compare against the queue.
    always @(negedge Clk) begin
        exp_t e;
        obs_t a;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = '{pclk:int'(d_pclk), hs:int'(d_hs), vs:int'(d_vs), blank:int'(d_blank),
                  sync:int'(d_sync), x:int'(d_x), y:int'(d_y), fs:int'(d_fs)};
            cmp("std", a, e.d);
            a = '{pclk:int'(s_pclk), hs:int'(s_hs), vs:int'(s_vs), blank:int'(s_blank),
                  sync:int'(s_sync), x:int'(s_x), y:int'(s_y), fs:int'(s_fs)};
            cmp("small", a, e.s);
        end
    end

    task automatic release_reset();
        @(negedge Clk);
        #2 Reset = 1'b0;
    endtask

    initial begin
        int tx, ty, tp, found;

        // Reset held 10 Clk, then a run longer than three small frames and
        // more than one standard line.
        repeat (10) @(negedge Clk);
        release_reset();
        repeat (3 * 950 + 100) @(posedge Clk);

        // Asynchronous reset while the small raster sits inside both syncs.
        tx = $urandom_range(SHV + SHF, SHV + SHF + SHS - 1);
        ty = $urandom_range(SVV + SVF, SVV + SVF + SVS - 1);
        tp = ty * 25 + tx;
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            @(posedge Clk);
            if ((k / 2) % 475 == tp) found = 1;
        end
        chk("sync_target_reached", found, 1);
        #1;
        chk("pre_reset.hs", int'(s_hs), 0);
        chk("pre_reset.vs", int'(s_vs), 0);
        #1 Reset = 1'b1;
        #1;
        chk("async_reset.hs",    int'(s_hs), 1);
        chk("async_reset.vs",    int'(s_vs), 1);
        chk("async_reset.DrawX", int'(s_x),  0);
        chk("async_reset.DrawY", int'(s_y),  0);
        chk("async_reset.std_X", int'(d_x),  0);
        repeat ($urandom_range(2, 6)) @(negedge Clk);
        release_reset();

        // Random run lengths interrupted by resets at random mid-cycle points.
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(100, 1500)) @(posedge Clk);
            #($urandom_range(1, 4)) Reset = 1'b1;
            repeat ($urandom_range(1, 5)) @(negedge Clk);
            release_reset();
        end
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Produces the 640x480 @ 60 Hz VGA raster timing for the display path. From the 50 MHz system clock it generates:
- the 25 MHz pixel clock;
- the horizontal and vertical sync pulses;
- the active-video flag `blank`;
- the `DrawX`/`DrawY` pixel coordinates consumed by the sprite and image mapper blocks.

It sits between the board clock and every mapper. Mappers read `DrawX`, `DrawY` and `blank` and return RGB.

## Interface

Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `Clk` input 1: 50 MHz system clock. Single clock domain.
- `Reset` input 1: asynchronous, active-high reset.
- `pixel_clk` output 1: Clk/2, driven from a register.
- `hs` output 1: horizontal sync, active-low.
- `vs` output 1: vertical sync, active-low.
- `blank` output 1: 1 = active video, 0 = blanking.
- `sync` output 1: composite sync, tied to 0.
- `DrawX` output 10: horizontal pixel counter, 0..H_TOTAL-1.
- `DrawY` output 10: vertical line counter, 0..V_TOTAL-1.
- `frame_start` output 1: one-Clk pulse when the raster wraps to (0,0).

## Operation

Derived totals:
- H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP = 800.
- V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP = 525.

Pixel enable and clock:
- Internal `pix_en` toggles every Clk.
- `pixel_clk` equals `pix_en`.
- Counters advance only on Clk edges where `pix_en` = 1. Each pixel therefore occupies exactly 2 Clk cycles.

Horizontal counter (`DrawX`):
- Increments on each enabled edge.
- At H_TOTAL-1 it wraps to 0 and issues a line-end strobe.

Vertical counter (`DrawY`):
- Increments only on the line-end strobe.
- Wraps from V_TOTAL-1 to 0.

Sync and blank:
- `hs` = 0 iff H_VISIBLE+H_FP ≤ DrawX < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
- `vs` = 0 iff V_VISIBLE+V_FP ≤ DrawY < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491.
- `blank` = 1 iff DrawX < 640 and DrawY < 480.
- `hs`, `vs` and `blank` are registered. Each is computed from the next counter values so it always matches the `DrawX`/`DrawY` presented in the same cycle. No skew between outputs.

`frame_start`:
- High for exactly one Clk cycle: the first cycle in which the counters show (0,0) after a wrap from (799,524).
- Not asserted on the cycle when reset is released.

Reset:
- Values while asserted: `pix_en` = 0, `DrawX` = 0, `DrawY` = 0, `hs` = 1, `vs` = 1, `blank` = 1 (0,0 is visible), `frame_start` = 0, `sync` = 0.
- Reset mid-line or mid-frame immediately forces these values. No partial sync pulse may persist.

Boundary conditions:
- Simultaneous horizontal and vertical wrap at (799,524) goes to (0,0) in a single enabled edge.
- Counters never exceed TOTAL-1.
- `DrawX`/`DrawY` are raw counters, not clamped. Mappers must gate on `blank`.

## Timing

- Line period: 1600 Clk. Frame period: 840 000 Clk.
- First enabled edge is the second Clk edge after reset deassertion. `DrawX` reads 1 from then on.
- Output latency from counter state to `hs`/`vs`/`blank`: 0 cycles as observed; these are pre-computed registers.
- Mapper contract: mappers register RGB one Clk after `DrawX`/`DrawY`. Each pixel is held for 2 Clk, so the registered RGB lands inside the same pixel.

## Structure

- Shared package `vga_pkg`:
  - the eight default timing constants;
  - derived H_TOTAL and V_TOTAL;
  - `typedef logic [9:0] coord_t`.
- One sub-module, `vga_axis_counter`. Parameterized on total, sync start and sync end; has an enable input.
  - Outputs: count, wrap strobe, registered active-low sync, visible flag.
  - Instantiated twice: horizontal with enable = `pix_en`; vertical with enable = horizontal wrap.

## Test plan

- Reset held 10 Clk, then released → `DrawX`=0, `DrawY`=0, `hs`=`vs`=1, `blank`=1 during reset; `DrawX`=1 two Clk edges after release.
- Run one line → `hs` low for exactly 192 Clk, beginning when `DrawX`=656. `blank` falls when `DrawX`=640. `DrawY` increments when `DrawX` wraps 799→0.
- Run full frame → `vs` low exactly during `DrawY`=490..491 (3200 Clk). `blank`=0 for all `DrawY` ≥ 480.
- Two consecutive frames → `frame_start` pulses are exactly 840 000 Clk apart, each 1 Clk wide, coincident with `DrawX`=`DrawY`=0.
- Assert `Reset` asynchronously (mid-cycle) at `DrawX`=700, `DrawY`=490, i.e. inside both syncs → `hs` and `vs` return to 1 immediately. Counters read 0 before the next Clk edge.
- Scoreboard over 3 frames → `blank`, `hs` and `vs` match a reference model computed from `DrawX`/`DrawY` every cycle. `pixel_clk` toggles every Clk.
